// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encodings, the divide-by-zero quotient fill value and
// the iteration-counter width helper used by seq_divider.
package seq_divider_pkg;

  // FSM state encodings (plain constants so legacy tools can consume them)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Divide-by-zero quotient is this bit replicated across the result (all ones)
  localparam logic DBZ_QUOT_FILL = 1'b1;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step.
// Ports: rem_in/bit_in form the shifted partial remainder, dsr is the divisor
// magnitude; rem_out is the next partial remainder, q_bit the quotient bit.
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // Trial subtraction is one bit wider than the operands so its msb is the
  // borrow: a set msb means the shifted remainder was smaller than dsr.
  assign trial = {rem_in, bit_in} - {1'b0, dsr};
  assign q_bit = ~trial[WIDTH];

  // When the trial fails the shifted remainder is < dsr, so its top bit is
  // zero and the low WIDTH bits are the full restored value.
  assign rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], bit_in};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider (MIPS DIV/DIVU), one quotient bit per clock.
// Ports: clk/reset (async, active-high); start, is_signed, dividend, divisor in;
// busy, done (1-cycle pulse), quotient (LO), remainder (HI), div_by_zero out.
// Build option: define SEQ_DIVIDER_SIGNED_EN to honour is_signed; otherwise all
// operations are unsigned and the sign handling logic is not built.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_sr;    // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] dsr_mag;   // latched divisor magnitude

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic             div_zero;
  logic             load_run;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign div_zero = (divisor == '0);

  // A request is taken only outside RUN; a zero divisor skips RUN entirely.
  assign load_run = (state != ST_RUN) && start && !div_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic dvd_neg;
  logic dsr_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dsr_neg = is_signed & divisor[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dsr_abs = dsr_neg ? -divisor  : divisor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load_run) begin
      neg_q <= dvd_neg ^ dsr_neg;
      neg_r <= dvd_neg;
    end
  end

  // Truncating division: quotient sign from operand signs, remainder follows dividend.
  assign q_res = neg_q ? -q_raw : q_raw;
  assign r_res = neg_r ? -r_raw : r_raw;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  assign dvd_abs = dividend;
  assign dsr_abs = divisor;
  assign q_res   = q_raw;
  assign r_res   = r_raw;
`endif

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (dvd_sr[WIDTH-1]),
    .dsr     (dsr_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Results as they stand after the current step (used on the last RUN cycle)
  assign q_raw = {dvd_sr[WIDTH-2:0], step_q};
  assign r_raw = step_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      dvd_sr      <= '0;
      rem         <= '0;
      dsr_mag     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (div_zero) begin
              state       <= ST_DONE;
              quotient    <= {WIDTH{DBZ_QUOT_FILL}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state   <= ST_RUN;
              dvd_sr  <= dvd_abs;
              dsr_mag <= dsr_abs;
              rem     <= '0;
              count   <= CW'(WIDTH);
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          dvd_sr <= q_raw;
          rem    <= step_rem;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            state       <= ST_DONE;
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        start32, sgn32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dbz32;
  logic [31:0] q32, r32;

  logic        start4, sgn4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, dbz4;
  logic [3:0]  q4, r4;

  int errors = 0;
  int checks = 0;

  exp_t exp32_q[$];
  exp_t exp4_q[$];

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
  );

  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .is_signed(sgn4),
    .dividend(a4), .divisor(b4), .busy(busy4), .done(done4),
    .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Scoreboard monitors: pop an expectation whenever a done pulse is seen
  always @(negedge clk) begin
    exp_t e;
    if (done32) begin
      if (exp32_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done32: got done=1 expected no pending result");
      end else begin
        e = exp32_q.pop_front();
        chk({e.nm, "_quotient"}, q32, e.q);
        chk({e.nm, "_remainder"}, r32, e.r);
        chk({e.nm, "_dbz"}, {31'b0, dbz32}, {31'b0, e.dbz});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done4: got done=1 expected no pending result");
      end else begin
        e = exp4_q.pop_front();
        chk({e.nm, "_q"}, {28'b0, q4}, e.q);
        chk({e.nm, "_r"}, {28'b0, r4}, e.r);
        chk({e.nm, "_dbz"}, {31'b0, dbz4}, {31'b0, e.dbz});
      end
    end
  end

  // Golden model for WIDTH=4 built from the language's / and %
  function automatic exp_t model4(input int s, input int a, input int b);
    exp_t e;
    int sa, sb, qq, rr;
    e.nm = $sformatf("w4_s%0d_%0d_%0d", s, a, b);
    if (b == 0) begin
      qq = 15; rr = a; e.dbz = 1'b1;
    end else if (s != 0 && SGN_EN) begin
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      qq = sa / sb; rr = sa % sb; e.dbz = 1'b0;
    end else begin
      qq = a / b; rr = a % b; e.dbz = 1'b0;
    end
    e.q = 32'(qq & 15);
    e.r = 32'(rr & 15);
    return e;
  endfunction

  // Issue one 32-bit division and check its timing; rp>0 re-pulses start in that cycle
  task automatic run32(input string nm, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input bit edbz, input int rp);
    exp_t e;
    int cyc, bcnt, exp_done;
    bit got;
    exp_done = (b == 32'd0) ? 1 : 33;
    @(posedge clk); #1;
    e.nm = nm; e.q = eq; e.r = er; e.dbz = edbz;
    exp32_q.push_back(e);
    start32 = 1'b1; sgn32 = s; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 1; bcnt = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (done32) begin
        got = 1'b1;
        chk({nm, "_busy_at_done"}, {31'b0, busy32}, 32'd0);
      end else begin
        if (busy32) bcnt++;
        if (rp != 0 && cyc == rp) begin
          start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd50; b32 = 32'd5;
        end else begin
          start32 = 1'b0;
        end
        cyc++;
      end
    end
    start32 = 1'b0;
    chk({nm, "_done_cycle"}, cyc, exp_done);
    chk({nm, "_busy_cycles"}, bcnt, exp_done - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, dcnt, exp_lat;
    bit got;
    exp_t e;

    reset = 1'b1;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start4  = 1'b0; sgn4  = 1'b0; a4  = '0; b4  = '0;

    @(negedge clk);
    chk("rst_busy32", {31'b0, busy32}, 32'd0);
    chk("rst_done32", {31'b0, done32}, 32'd0);
    chk("rst_q32", q32, 32'd0);
    chk("rst_r32", r32, 32'd0);
    chk("rst_dbz32", {31'b0, dbz32}, 32'd0);
    chk("rst_busy4", {31'b0, busy4}, 32'd0);
    chk("rst_q4", {28'b0, q4}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run32("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    run32("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
          SGN_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
          SGN_EN ? 32'hFFFF_FFFF : 32'd1, 1'b0, 0);
    run32("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
          SGN_EN ? 32'hFFFF_FFFD : 32'd0,
          SGN_EN ? 32'd1 : 32'd7, 1'b0, 0);
    run32("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run32("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run32("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);
    run32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
          SGN_EN ? 32'h8000_0000 : 32'd0,
          SGN_EN ? 32'd0 : 32'h8000_0000, 1'b0, 0);
    run32("u_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 0);
    run32("repulse", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 10);

    // Reset in cycle 15 of a run: outputs clear at once, no done follows
    @(posedge clk); #1;
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    chk("midrun_busy_c14", {31'b0, busy32}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy32}, 32'd0);
    chk("abort_done", {31'b0, done32}, 32'd0);
    chk("abort_q", q32, 32'd0);
    chk("abort_r", r32, 32'd0);
    chk("abort_dbz", {31'b0, dbz32}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);

    // Exhaustive WIDTH=4, each new start issued in the previous done cycle
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          e = model4(s, a, b);
          exp4_q.push_back(e);
          exp_lat = (b == 0) ? 1 : 5;
          start4 = 1'b1; sgn4 = s[0]; a4 = a[3:0]; b4 = b[3:0];
          @(posedge clk); #1;
          start4 = 1'b0;
          lat = 1; bcnt = 0; got = 1'b0;
          while (!got && lat <= 10) begin
            @(negedge clk);
            if (done4) got = 1'b1;
            else begin
              if (busy4) bcnt++;
              lat++;
            end
          end
          chk({e.nm, "_lat"}, lat, exp_lat);
          chk({e.nm, "_busy"}, bcnt, exp_lat - 1);
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("drain32", exp32_q.size(), 32'd0);
    chk("drain4", exp4_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring integer divider serving the MIPS DIV/DIVU path.
- Where the combinational ripple-carry adder produces a sum in one pass, this block runs the inverse operation: one trial subtraction per clock, producing quotient and remainder into the HI/LO path.
- A start/busy/done handshake lets the pipeline stall the issuing instruction until results are ready.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled on rising clk.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  division in progress.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  WIDTH  result to LO.
- remainder  output  WIDTH  result to HI.
- div_by_zero  output  1  last accepted operation had divisor = 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 with divisor ≠ 0 -> RUN.
  - Latch operand magnitudes (absolute values when signed).
  - Latch sign flags.
  - Clear partial remainder.
  - Set count = WIDTH.
- IDLE/DONE + start=1 with divisor = 0 -> DONE directly; no RUN cycles.
- RUN step, one per cycle:
  - Form {rem, msb of dividend shift register} (WIDTH+1 bits).
  - Subtract divisor magnitude.
  - If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement count.
- RUN with count = 1 -> DONE. On that edge, register the final results with sign fixup:
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when the dividend was negative.
- DONE -> IDLE after one cycle unless start is sampled high in DONE, which is accepted as a new request.
- start while in RUN is ignored; latched operands are unaffected.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified, any sign), div_by_zero = 1.
- Signed overflow (most-negative / −1): quotient = most-negative value, remainder = 0, div_by_zero = 0. This falls out of magnitude arithmetic plus negation; no special case is needed.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned; the trial subtraction is WIDTH+1 bits.
  - Negation is two's complement, modulo 2^WIDTH.

## Timing
- Reset values: state = IDLE; busy = 0, done = 0, div_by_zero = 0, quotient = 0, remainder = 0.
- Reset mid-RUN aborts immediately. No done is produced.
- Normal latency, with the start-sampling edge ending cycle 0:
  - busy = 1 in cycles 1..WIDTH.
  - done = 1 in cycle WIDTH+1, with busy = 0.
- Divide by zero: busy never asserts; done = 1 in cycle 1.
- quotient, remainder and div_by_zero change only on the DONE-entry edge and hold until the next DONE entry or reset.
- A back-to-back start in the done cycle gives busy in the very next cycle, so throughput is one result per WIDTH+1 cycles.

## Configuration
- Macro SEQ_DIVIDER_SIGNED_EN.
- Defined: is_signed is honoured as above.
- Undefined:
  - is_signed is ignored and all operations are unsigned.
  - Sign latch and fixup logic are removed.
  - Divide-by-zero and latency behaviour are unchanged.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the divide-by-zero quotient constant (all ones);
  - a WIDTH-dependent count-width helper, $clog2(WIDTH+1).
- Natural sub-module: div_step, a combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
- The top block holds the FSM, counter, shift registers and sign fixup.

## Test plan
- Unsigned 100 / 7, WIDTH=32 -> quotient 14, remainder 2, done in exactly cycle 33, busy high in cycles 1..32.
- Signed −7 / 2 -> quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). With macro undefined -> quotient 0x7FFFFFFC, remainder 1.
- 5 / 0 (either mode) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero = 1, done in cycle 1, busy never high.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero = 0.
- Handshake edge cases:
  - start re-pulsed in cycle 10 with new operands -> ignored; original result delivered in cycle 33.
  - reset asserted in cycle 15 -> all outputs 0 and IDLE immediately; no done pulse.
- Exhaustive WIDTH=4:
  - all 256 dividend/divisor pairs, both is_signed values;
  - back-to-back starts issued in each done cycle;
  - compared against a golden model (/ and % with the divide-by-zero rule).
  - Required: zero mismatches.
